pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder with a valid/ready handshake on both sides. An N-bit add is split into STAGES equal chunks, one chunk per pipeline stage. The carry is registered between stages, so one new operand pair is accepted per cycle at full throughput. It is the scalable replacement for the fixed-width combinational adders in the arithmetic library, for datapaths whose width no longer closes timing in a single ripple.

## Interface
Parameters:
- WIDTH, 32, operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4, number of pipeline stages, range 1..WIDTH; chunk width CW = WIDTH/STAGES.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand pair a/b/cin is valid this cycle.
- in_ready  output  1  pipeline can accept an operand pair this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum/cout are valid.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- sub  input  1  only when ADDER_SUB_EN is defined; selects subtraction.

## Operation
- Stage k (0..STAGES-1) adds chunk k: a[k*CW +: CW] + b[k*CW +: CW] + carry_k.
  - carry_0 = cin; carry_k is stage k-1's registered carry-out.
- Operand chunks above k travel alongside the data in skew registers until their stage.
- Sum chunks below k are carried forward in deskew registers.
- All chunks of one transaction emerge together.
- Each stage has a valid bit; the last stage's valid is out_valid.
- Global advance: en = !out_valid || out_ready. When en=1, every stage register loads from its predecessor, and stage 0 loads the inputs.
- in_ready = en. A transfer occurs when in_valid && in_ready. If in_valid=0 while en=1, a bubble (valid=0) enters stage 0.
- While en=0, all stage registers, including out_valid/sum/cout, hold their values.
- Arithmetic: result is exactly {cout,sum} = a + b + cin on WIDTH+1 bits. No saturation and no overflow flag.
- STAGES=1: a single registered adder with latency 1.
- Reset: all valid bits clear to 0. sum, cout and all data registers clear to 0. in_ready = 1 immediately after reset.
- Reset asserted mid-operation discards every in-flight transaction; none appears after reset release.

## Timing
- Latency: STAGES cycles from an accepted input to out_valid=1 with that result, when there is no backpressure.
- Throughput: one transaction per cycle while out_ready=1.
- Outputs are registered; there is no combinational path from a/b/cin to sum/cout.
- in_ready depends combinationally on out_ready and out_valid only.
- Backpressure (out_valid=1, out_ready=0): in_ready=0 in the same cycle, and the whole pipeline freezes.
- Bubbles are not compressed during a stall.
- A result is held stable until the cycle in which out_ready=1.
- When the pipeline is empty, out_valid=0 and in_ready=1 regardless of out_ready.
- Simultaneous accept and output consume in one cycle is allowed; the pipeline shifts by one.

## Configuration
- ADDER_SUB_EN defined: port sub exists and is sampled with a/b at acceptance.
  - sub=1 computes a + ~b + 1; cin is ignored for that transaction.
  - cout=1 means no borrow (a >= b unsigned).
  - sub travels down the pipeline with its transaction.
- ADDER_SUB_EN undefined: no sub port; the block is a pure adder.

## Test plan
- WIDTH=8, STAGES=2: a=8'hFF, b=8'h01, cin=0, out_ready=1 -> exactly 2 cycles later out_valid=1, sum=8'h00, cout=1. This checks the inter-stage carry.
- WIDTH=8, STAGES=2: back-to-back inputs (10+20), (200+100), (0+0, cin=1), out_ready=1 -> results 30/c0, 44/c1, 1/c0 on consecutive cycles, in order, with no gaps.
- Backpressure: issue 3 transactions, hold out_ready=0 for 5 cycles -> in_ready=0, first result held stable for the whole stall. After release, all 3 results emerge in order and none are lost or duplicated.
- Reset mid-flight: 2 transactions in the pipeline, pulse rst_n low asynchronously (between clock edges) -> out_valid=0, sum=0, cout=0 immediately. After release, no stale results appear and in_ready=1.
- WIDTH=32, STAGES=1, 4 and 32: 10k random a/b/cin with random in_valid/out_ready -> every result matches a reference {cout,sum}, order is preserved, and the transaction count matches.
- ADDER_SUB_EN, WIDTH=8, STAGES=2: sub=1, a=5, b=7 -> sum=8'hFE, cout=0. Then sub=1, a=7, b=5 -> sum=8'h02, cout=1.

Source files
------------

// File: rtl/pipelined_adder.sv
`timescale 1ns/1ps
// pipelined_adder: WIDTH-bit ripple-carry adder cut into STAGES registered chunks, valid/ready on both sides.
// Define ADDER_SUB_EN to add a sub port that selects a - b (a + ~b + 1).
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int CW = WIDTH / STAGES;

  logic                          en;
  logic [WIDTH-1:0]              b_eff;
  logic                          cin_eff;

  logic [STAGES-1:0][WIDTH-1:0]  a_q, b_q, s_q;
  logic [STAGES-1:0]             c_q, v_q;

  logic [STAGES-1:0][WIDTH-1:0]  a_src, b_src, s_src, s_nxt;
  logic [STAGES-1:0]             c_src, v_src, c_nxt;

  // Subtraction inverts b once at acceptance; the inverted operand then rides the
  // skew registers, so the mode follows its transaction without a separate flag.
`ifdef ADDER_SUB_EN
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign en        = !out_valid || out_ready;
  assign in_ready  = en;
  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign cout      = c_q[STAGES-1];

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [CW:0]      add_k;
    logic [WIDTH-1:0] merged;

    if (k == 0) begin : g_first
      assign a_src[k] = a;
      assign b_src[k] = b_eff;
      assign s_src[k] = '0;
      assign c_src[k] = cin_eff;
      assign v_src[k] = in_valid;
    end else begin : g_next
      assign a_src[k] = a_q[k-1];
      assign b_src[k] = b_q[k-1];
      assign s_src[k] = s_q[k-1];
      assign c_src[k] = c_q[k-1];
      assign v_src[k] = v_q[k-1];
    end

    assign add_k = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
                 + {{CW{1'b0}}, c_src[k]};

    always_comb begin
      merged               = s_src[k];
      merged[k*CW +: CW]   = add_k[CW-1:0];
    end

    assign s_nxt[k] = merged;
    assign c_nxt[k] = add_k[CW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q <= '0;
      b_q <= '0;
      s_q <= '0;
      c_q <= '0;
      v_q <= '0;
    end else if (en) begin
      a_q <= a_src;
      b_q <= b_src;
      s_q <= s_nxt;
      c_q <= c_nxt;
      v_q <= v_src;
    end
  end

  // Already-consumed low operand chunks and the last stage's operands are dead; synthesis trims them.
  logic unused_ok;
  assign unused_ok = ^{a_q, b_q};

endmodule

// File: tb/tb_pipelined_adder.sv
`timescale 1ns/1ps
// Self-checking bench for pipelined_adder at WIDTH=8, STAGES=2: directed cases plus randomized
// traffic scored against a queue-based arithmetic reference.
module tb_pipelined_adder;
  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid, out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int checks   = 0;
  int failures = 0;

  pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    in_valid = v;
    a        = av;
    b        = bv;
    cin      = c;
  endtask

  function automatic logic [W:0] ref_add(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
    int unsigned t;
    t = int'(av) + int'(bv) + int'(c);
    return t[W:0];
  endfunction

  logic [W:0]   q[$];
  logic [W:0]   exp_r;
  logic [W:0]   bb_exp [3];
  logic [W-1:0] bb_a [3];
  logic [W-1:0] bb_b [3];
  logic         bb_c [3];
  logic         hold_prev;
  logic [W+1:0] prev_out;
  int           n_in, n_out;

  initial begin
    rst_n = 1'b1; sub = 1'b0; out_ready = 1'b0;
    drive(1'b0, '0, '0, 1'b0);
    #1 rst_n = 1'b0;
    #2;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_sum", sum, '0);
    chk("reset_cout", cout, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    #10 rst_n = 1'b1;
    step();

    // inter-stage carry: FF + 01
    out_ready = 1'b1;
    drive(1'b1, 8'hFF, 8'h01, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk("carry_lat1_valid", out_valid, 1'b0);
    step();
    chk("carry_valid", out_valid, 1'b1);
    chk("carry_sum_cout", {cout, sum}, 9'h100);
    step();
    chk("carry_bubble", out_valid, 1'b0);

    // back-to-back, full throughput
    bb_a = '{8'd10, 8'd200, 8'd0};
    bb_b = '{8'd20, 8'd100, 8'd0};
    bb_c = '{1'b0, 1'b0, 1'b1};
    bb_exp = '{9'd30, {1'b1, 8'd44}, 9'd1};
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, bb_a[i], bb_b[i], bb_c[i]);
      step();
      if (i >= 1) begin
        chk($sformatf("b2b_valid_%0d", i - 1), out_valid, 1'b1);
        chk($sformatf("b2b_res_%0d", i - 1), {cout, sum}, bb_exp[i-1]);
      end
    end
    drive(1'b0, '0, '0, 1'b0);
    step();
    chk("b2b_valid_2", out_valid, 1'b1);
    chk("b2b_res_2", {cout, sum}, bb_exp[2]);
    step();
    chk("b2b_drained", out_valid, 1'b0);

    // backpressure: third transaction waits while the full pipeline is frozen
    out_ready = 1'b0;
    drive(1'b1, 8'd1, 8'd2, 1'b0);
    step();
    drive(1'b1, 8'd3, 8'd4, 1'b0);
    step();
    drive(1'b1, 8'hF0, 8'h20, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk($sformatf("stall_in_ready_%0d", i), in_ready, 1'b0);
      chk($sformatf("stall_hold_%0d", i), {out_valid, cout, sum}, {1'b1, 9'd3});
      step();
    end
    out_ready = 1'b1;
    #1;
    chk("release_in_ready", in_ready, 1'b1);
    chk("release_res0", {out_valid, cout, sum}, {1'b1, 9'd3});
    step();
    drive(1'b0, '0, '0, 1'b0);
    chk("release_res1", {out_valid, cout, sum}, {1'b1, 9'd7});
    step();
    chk("release_res2", {out_valid, cout, sum}, {1'b1, 9'h110});
    step();
    chk("release_empty", out_valid, 1'b0);

    // asynchronous reset with two transactions in flight
    drive(1'b1, 8'h55, 8'h66, 1'b1);
    step();
    drive(1'b1, 8'h77, 8'h88, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_sum_cout", {cout, sum}, 9'd0);
    #3 rst_n = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      step();
      chk($sformatf("postrst_no_stale_%0d", i), out_valid, 1'b0);
      chk($sformatf("postrst_in_ready_%0d", i), in_ready, 1'b1);
    end

`ifdef ADDER_SUB_EN
    sub = 1'b1;
    drive(1'b1, 8'd5, 8'd7, 1'b0);
    step();
    drive(1'b1, 8'd7, 8'd5, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b0);
    sub = 1'b0;
    chk("sub_5_7", {out_valid, cout, sum}, {1'b1, 1'b0, 8'hFE});
    step();
    chk("sub_7_5", {out_valid, cout, sum}, {1'b1, 1'b1, 8'h02});
    step();
`endif

    // randomized traffic against the queue reference
    q.delete();
    hold_prev = 1'b0;
    prev_out  = '0;
    n_in = 0;
    n_out = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      drive(1'($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
      out_ready = 1'($urandom_range(0, 3) != 0);
      #1;
      if (hold_prev) chk("rnd_stall_stable", {out_valid, cout, sum}, prev_out);
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("rnd_unexpected_output", 1'b1, 1'b0);
        else begin
          exp_r = q.pop_front();
          chk("rnd_result", {cout, sum}, exp_r);
        end
        n_out++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_add(a, b, cin));
        n_in++;
      end
      hold_prev = out_valid && !out_ready;
      prev_out  = {out_valid, cout, sum};
      step();
    end
    drive(1'b0, '0, '0, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < S + 2; i++) begin
      #1;
      if (out_valid) begin
        if (q.size() == 0) chk("drain_unexpected_output", 1'b1, 1'b0);
        else begin
          exp_r = q.pop_front();
          chk("drain_result", {cout, sum}, exp_r);
        end
        n_out++;
      end
      step();
    end
    chk("rnd_txn_count", 64'(n_out), 64'(n_in));
    chk("rnd_queue_empty", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
